ones_count_seq: RTL and testbench
=================================

ONES_COUNT_SEQ -- requirements
Module: ones_count_seq

Interface
REQ-001 Parameter: EARLY_EXIT, 0, 1 = leave SHIFT as soon as no set bits remain; 0 = always process all 15 bits.
REQ-002 Parameter: MAJ_THRESH, 8, out_majority threshold on the ones count (valid range 0..15).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  in_data is valid this cycle.
REQ-007 Port: in_ready  output  1  block can accept a word; high only in IDLE with rst low.
REQ-008 Port: in_data  input  15  word whose set bits are counted; bit 0 is processed first.
REQ-009 Port: out_valid  output  1  result is available; high only in DONE.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: out_count  output  4  number of set bits in the accepted word (0..15).
REQ-012 Port: out_majority  output  1  out_count >= MAJ_THRESH.
REQ-013 Port: busy  output  1  high in SHIFT and DONE.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-015 Cycle numbering: cycle 0 is the accept cycle (in_valid && in_ready high at a rising edge).
REQ-016 On accept, the block SHALL:
  - load a 15-bit shift register with in_data;
  - clear the accumulator and the 4-bit bit index;
  - enter SHIFT in cycle 1.
REQ-017 In each SHIFT cycle, the block SHALL:
  - add shreg[0] to the 4-bit accumulator;
  - shift shreg right by one with zero fill;
  - increment the bit index.
  The accumulator never exceeds 15, so no overflow handling is needed.
REQ-018 With EARLY_EXIT=0, the SHIFT cycle that processes bit 14 (cycle 15) SHALL transition to DONE, so out_valid first rises in cycle 16.
REQ-019 With EARLY_EXIT=1, a SHIFT cycle whose post-shift shreg is all-zero SHALL transition to DONE.
  - out_valid rises one cycle after the highest set bit is processed.
  - An all-zero word reaches DONE in cycle 2.
REQ-020 On entry to DONE, out_count and out_majority SHALL be registered from the final accumulator value.
  - Both hold stable for as long as out_valid is high.
  - Both keep their value after leaving DONE, until the next DONE entry.
REQ-021 In DONE with out_ready high, the block SHALL return to IDLE on the next edge; with out_ready low it SHALL stay in DONE (backpressure, no cycle limit).
REQ-022 in_ready SHALL be low in SHIFT and DONE; in_valid is ignored there and no second word is queued.
REQ-023 in_data SHALL be sampled only in the accept cycle; later changes to it do not affect the result.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 A new word SHALL be accepted no earlier than the cycle after DONE is left (minimum IDLE dwell of 1 cycle).

Reset
REQ-026 While rst is high at a rising edge, the block SHALL set:
  - state = IDLE;
  - shreg = 0, accumulator = 0, bit index = 0;
  - out_count = 0, out_majority = 0, out_valid = 0, busy = 0.
REQ-027 in_ready SHALL be held at 0 in any cycle where rst is high.
REQ-028 Reset in SHIFT or DONE SHALL abort the operation and discard the partial result; no out_valid pulse follows.
REQ-029 After rst deasserts, the first word SHALL be accepted normally.

Verification
REQ-030 EARLY_EXIT=0, in_data=15'b000000000000000, out_ready=1 -> out_valid in cycle 16 only, out_count=0, out_majority=0.
REQ-031 in_data=15'b101011011100110 -> out_count=9, out_majority=1.
REQ-032 in_data=15'h7FFF -> out_count=15, out_majority=1.
REQ-033 in_data=15'h0200 -> out_count=1, out_majority=0.
  - EARLY_EXIT=0: out_valid in cycle 16.
  - EARLY_EXIT=1: out_valid in cycle 11.
REQ-034 Backpressure: in_data=15'b001000100000010, out_ready held low for 5 cycles in DONE while in_valid pulses:
  - out_valid stays 1 and out_count stays 3 throughout;
  - in_ready stays 0 and the in_valid pulses are not accepted;
  - after out_ready rises, the block is back in IDLE one cycle later.
REQ-035 Reset mid-operation: rst pulsed in cycle 7 of SHIFT with in_data=15'h7FFF -> IDLE and all outputs 0; no out_valid; the next word, 15'b000100001000000, yields out_count=2.

Source files
------------

// File: rtl/ones_count_seq.sv
// Bit-serial population counter for 15-bit words with a valid/ready handshake on
// both sides. The word is scanned LSB first; EARLY_EXIT stops once no set bits remain.
module ones_count_seq #(
  parameter int unsigned EARLY_EXIT = 0,
  parameter int unsigned MAJ_THRESH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_count,
  output logic        out_majority,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [4:0] Thresh = 5'(MAJ_THRESH);

  state_e      state_q, state_d;
  logic [14:0] shreg_q, shreg_d;
  logic [3:0]  acc_q, acc_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  count_q, count_d;
  logic        maj_q, maj_d;

  logic [14:0] shreg_next;
  logic [3:0]  acc_next;
  logic        last_step;

  always_comb begin
    acc_next   = acc_q + {3'b000, shreg_q[0]};
    shreg_next = {1'b0, shreg_q[14:1]};
    // Bit 14 always ends the scan; early exit also ends it once the remainder is empty.
    last_step  = (idx_q == 4'd14) || ((EARLY_EXIT != 0) && (shreg_next == '0));
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    count_d = count_q;
    maj_d   = maj_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shreg_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d = shreg_next;
        acc_d   = acc_next;
        idx_d   = idx_q + 4'd1;
        if (last_step) begin
          state_d = StDone;
          count_d = acc_next;
          maj_d   = ({1'b0, acc_next} >= Thresh);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      maj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      maj_q   <= maj_d;
    end
  end

  assign in_ready     = (state_q == StIdle) && !rst;
  assign out_valid    = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign out_count    = count_q;
  assign out_majority = maj_q;

endmodule

// File: tb/tb_ones_count_seq.sv
// Runs an EARLY_EXIT=0 and an EARLY_EXIT=1 instance in lockstep; each has a monitor that
// pops expectations from its own scoreboard queue, filled from a popcount reference model.
module tb_ones_count_seq;

  localparam int unsigned Maj = 8;

  typedef struct {
    int cnt;
    int maj;
    int lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [14:0] in_data;
  logic        or_rand = 1'b0;

  logic        in_ready_v [2];
  logic        out_valid_v[2];
  logic        out_maj_v  [2];
  logic        busy_v     [2];
  logic [3:0]  out_count_v[2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (or_rand) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input int g, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s (early_exit=%0d) cycle %0d: got %0d, want %0d", name, g, cyc, act, req);
    end
  endtask

  // Reference: plain popcount; latency counted from the accept cycle to the first valid cycle.
  function automatic exp_t model(input logic [14:0] w, input int ee);
    exp_t e;
    int   n;
    int   hi;
    n  = 0;
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      if (w[i]) begin
        n++;
        hi = i;
      end
    end
    e.cnt = n;
    e.maj = (n >= int'(Maj)) ? 1 : 0;
    e.lat = (ee != 0) ? hi + 2 : 16;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ones_count_seq #(
      .EARLY_EXIT(g),
      .MAJ_THRESH(Maj)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready_v[g]),
      .in_data     (in_data),
      .out_valid   (out_valid_v[g]),
      .out_ready   (out_ready),
      .out_count   (out_count_v[g]),
      .out_majority(out_maj_v[g]),
      .busy        (busy_v[g])
    );

    exp_t sb[$];
    int   acc_cyc  = 0;
    int   last_cnt = 0;
    int   last_maj = 0;

    initial forever begin
      bit idle;
      @(negedge clk);
      idle = (sb.size() == 0);
      if (rst) begin
        chk("in_ready_during_rst", g, int'(in_ready_v[g]), 0);
        sb.delete();
        last_cnt = 0;
        last_maj = 0;
      end else begin
        chk("in_ready", g, int'(in_ready_v[g]), int'(idle));
        chk("busy", g, int'(busy_v[g]), int'(!idle));
        if (!idle) chk("out_valid_timing", g, int'(out_valid_v[g]),
                       int'((cyc - acc_cyc) >= sb[0].lat));
        else       chk("out_valid_idle", g, int'(out_valid_v[g]), 0);
        if (out_valid_v[g] && !idle) begin
          chk("out_count", g, int'(out_count_v[g]), sb[0].cnt);
          chk("out_majority", g, int'(out_maj_v[g]), sb[0].maj);
          if (out_ready) begin
            last_cnt = sb[0].cnt;
            last_maj = sb[0].maj;
            void'(sb.pop_front());
          end
        end else begin
          chk("out_count_held", g, int'(out_count_v[g]), last_cnt);
          chk("out_majority_held", g, int'(out_maj_v[g]), last_maj);
        end
        if (in_valid && idle) begin
          sb.push_back(model(in_data, g));
          acc_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_sim();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // Pulses in_valid at random only while both instances refuse input.
  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready_v[0] && in_ready_v[1])) begin
      in_valid = (!in_ready_v[0] && !in_ready_v[1]) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n++;
      if (n > 300) begin
        chk("idle_timeout", 0, 1, 0);
        finish_sim();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_both_valid();
    int n;
    n = 0;
    while (!(out_valid_v[0] && out_valid_v[1])) begin
      tick();
      n++;
      if (n > 100) begin
        chk("valid_timeout", 0, 1, 0);
        finish_sim();
      end
    end
  endtask

  task automatic send(input logic [14:0] w);
    wait_idle();
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 15'($urandom);
  endtask

  initial begin
    logic [14:0] w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    repeat (3) tick();
    rst = 1'b0;

    send(15'b000000000000000);
    send(15'b101011011100110);
    send(15'h7FFF);
    send(15'h0200);

    // Backpressure: hold the result for 5 cycles while in_valid pulses.
    wait_idle();
    out_ready = 1'b0;
    send(15'b001000100000010);
    wait_both_valid();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset during cycle 7 of the scan.
    send(15'h7FFF);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(15'b000100001000000);

    or_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      unique case (i % 4)
        0:       w = 15'($urandom);
        1:       w = 15'($urandom) & 15'($urandom) & 15'($urandom);
        2:       w = 15'(1) << $urandom_range(0, 14);
        default: w = 15'($urandom) | 15'($urandom);
      endcase
      send(w);
    end
    or_rand   = 1'b0;
    #1;
    out_ready = 1'b1;
    wait_idle();
    repeat (3) tick();
    finish_sim();
  end

endmodule
